alu_4bit_issue_ctrl: RTL and testbench
======================================

Name: alu_4bit_issue_ctrl

Overview:
- Issue/writeback controller in front of alu_4bit.
- Accepts one 3-operand instruction at a time via valid/ready, reads two operands from a 4-entry x 4-bit register file, and drives A/B/Operation of an external alu_4bit.
- Captures Result/Zero/Overflow, writes Result back to the register file and reports a completion pulse.
- Keeps a sticky overflow flag for the software-visible status path.

Parameters:
- DATA_W, 4, operand/result width; must equal alu_4bit width.
- NUM_REGS, 4, register-file depth; register index width is 2 bits.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- InValid  in  1  instruction present.
- InReady  out  1  controller can accept this cycle.
- InOp  in  3  opcode: ALU encoding (000 AND, 001 OR, 010 ADD, 011 NAND, 100 NOR, 110 SUB, 111 SLT), plus 101 LOADI.
- InRd  in  2  destination register.
- InRs  in  2  source A register; for LOADI, Imm[3:2].
- InRt  in  2  source B register; for LOADI, Imm[1:0].
- AluA  out  4  to alu_4bit A.
- AluB  out  4  to alu_4bit B.
- AluOp  out  3  to alu_4bit Operation.
- AluResult  in  4  from alu_4bit Result (combinational).
- AluZero  in  1  from alu_4bit Zero.
- AluOverflow  in  1  from alu_4bit Overflow.
- DoneValid  out  1  one-cycle writeback pulse.
- DoneRd  out  2  register written.
- DoneResult  out  4  value written.
- DoneZero  out  1  zero flag of the completed op.
- DoneOverflow  out  1  overflow flag of the completed op.
- OverflowSticky  out  1  set by any completed op with overflow.
- ClearSticky  in  1  clears OverflowSticky.
- DbgAddr  in  2  debug read address.
- DbgData  out  4  combinational read of regfile[DbgAddr].

Behaviour:
- FSM states: IDLE -> EXEC -> WB -> IDLE; no other states.
- IDLE:
  - InReady=1 (forced 0 while Reset=1).
  - Accept when InValid && InReady; latch op/rd/rs/rt into the instruction register; go to EXEC.
  - InValid while not IDLE is ignored; the source must hold it until accepted.
- EXEC:
  - AluA=regfile[rs], AluB=regfile[rt], AluOp=op.
  - At the clock edge, register AluResult, AluZero and AluOverflow; go to WB.
  - LOADI: AluOp=000, AluA=AluB=0; the ALU response is ignored.
  - LOADI captured result = {rs,rt}; zero = ({rs,rt}==0); overflow = 0.
- WB:
  - Write regfile[rd] with the captured result.
  - DoneValid=1 for exactly this cycle, with DoneRd/DoneResult/DoneZero/DoneOverflow.
  - If the captured overflow is 1, set OverflowSticky at the edge. Go to IDLE.
- Latency: accept at edge N, EXEC during cycle N+1, DoneValid high in cycle N+2, regfile updated at the end of N+2. Throughput is 1 instruction per 3 cycles.
- Outside EXEC: AluA=0, AluB=0, AluOp=000. Outside WB: DoneValid=0; the other Done* outputs hold their last values.
- Hazards:
  - Operands are read in EXEC, after the previous WB has completed, so back-to-back dependent instructions always see the updated value. No forwarding is needed.
  - rd equal to rs or rt is legal: the old value is read, the new value is written.
- The DbgData read reflects a WB write starting the cycle after WB.
- If ClearSticky and a WB overflow occur in the same cycle, set wins.
- Reset (any state, including mid-EXEC/WB):
  - State=IDLE; all regfile entries=0; the in-flight instruction is discarded with no writeback.
  - DoneValid=0, DoneRd=0, DoneResult=0, DoneZero=0, DoneOverflow=0, OverflowSticky=0.
  - AluA/AluB/AluOp=0; InReady=0 during the Reset cycle.
- Arithmetic is done entirely in alu_4bit. This block adds no width extension and passes the 4-bit Result and flags unmodified.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_AND, OP_OR, OP_ADD, OP_NAND, OP_NOR, OP_LOADI, OP_SUB, OP_SLT.
  - DATA_W; REG_IDX_W=2.
  - FSM state enum {ST_IDLE, ST_EXEC, ST_WB}.
- One sub-module: alu_regfile, 4x4 storage with synchronous write port, two combinational read ports and one debug read port, cleared on Reset.
- alu_4bit stays external. The bench instantiates alu_4bit and ties it to the Alu* ports.

Test Plan:
- Reset, then LOADI r1=7 and LOADI r2=1, then ADD r3=r1+r2 -> DoneResult=1000, DoneOverflow=1, DoneZero=0, OverflowSticky=1; DbgAddr=3 gives 1000.
- With OverflowSticky=1, pulse ClearSticky alone -> OverflowSticky=0. Then repeat the ADD with ClearSticky held high in the WB cycle -> OverflowSticky=1 (set wins).
- Hold InValid=1 continuously -> InReady pattern 1,0,0 repeating; exactly one DoneValid every 3 cycles; accept-to-DoneValid is 2 cycles.
- Dependent chain: LOADI r0=5; SUB r0=r0-r0 -> result 0000, DoneZero=1. Then NOR r1=r0|r0 -> result 1111.
- r1=-3 (1101), r2=6 (0110), SLT r3 -> result 0000, DoneZero=1, DoneOverflow=1, matching alu_4bit's output for this case.
- Assert Reset during EXEC of ADD r3 -> no DoneValid, regfile all 0, InReady=1 the first cycle after Reset deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_4bit issue/writeback controller slice:
// opcode encodings, widths, FSM states and the instruction register layout.
`timescale 1ns/1ps
package alu_pkg;

    localparam int DATA_W    = 4;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_NOR   = 3'b100;
    localparam logic [2:0] OP_LOADI = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_e;

    typedef struct packed {
        logic [2:0]           op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
    } instr_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU driven by the issue controller.
// SLT reports the sign of A-B without overflow correction, as the original part does.
`timescale 1ns/1ps
module alu_4bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        Operation,
    output logic [DATA_W-1:0] Result,
    output logic              Zero,
    output logic              Overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;

    assign sum     = A + B;
    assign diff    = A - B;
    assign add_ovf = (A[DATA_W-1] == B[DATA_W-1]) &&
                     (sum[DATA_W-1] != A[DATA_W-1]);
    assign sub_ovf = (A[DATA_W-1] != B[DATA_W-1]) &&
                     (diff[DATA_W-1] != A[DATA_W-1]);

    always_comb begin
        Result   = '0;
        Overflow = 1'b0;
        unique case (Operation)
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_ADD: begin
                Result   = sum;
                Overflow = add_ovf;
            end
            OP_NAND: Result = ~(A & B);
            OP_NOR:  Result = ~(A | B);
            OP_SUB: begin
                Result   = diff;
                Overflow = sub_ovf;
            end
            OP_SLT: begin
                Result   = {{(DATA_W-1){1'b0}}, diff[DATA_W-1]};
                Overflow = sub_ovf;
            end
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, two operand read
// ports and a debug read port, all reads combinational.
`timescale 1ns/1ps
module alu_regfile #(
    parameter int DATA_W   = alu_pkg::DATA_W,
    parameter int NUM_REGS = alu_pkg::NUM_REGS,
    parameter int IDX_W    = alu_pkg::REG_IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [IDX_W-1:0]  dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_4bit_issue_ctrl.sv
// Issue/writeback controller for alu_4bit: IDLE -> EXEC -> WB, one
// instruction per three cycles, with a sticky overflow status bit.
`timescale 1ns/1ps
module alu_4bit_issue_ctrl #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [2:0]                    InOp,
    input  logic [alu_pkg::REG_IDX_W-1:0] InRd,
    input  logic [alu_pkg::REG_IDX_W-1:0] InRs,
    input  logic [alu_pkg::REG_IDX_W-1:0] InRt,
    output logic [DATA_W-1:0]             AluA,
    output logic [DATA_W-1:0]             AluB,
    output logic [2:0]                    AluOp,
    input  logic [DATA_W-1:0]             AluResult,
    input  logic                          AluZero,
    input  logic                          AluOverflow,
    output logic                          DoneValid,
    output logic [alu_pkg::REG_IDX_W-1:0] DoneRd,
    output logic [DATA_W-1:0]             DoneResult,
    output logic                          DoneZero,
    output logic                          DoneOverflow,
    output logic                          OverflowSticky,
    input  logic                          ClearSticky,
    input  logic [alu_pkg::REG_IDX_W-1:0] DbgAddr,
    output logic [DATA_W-1:0]             DbgData
);

    import alu_pkg::*;

    state_e                state_q, state_d;
    instr_t                ir_q;
    logic [REG_IDX_W-1:0]  rd_q;
    logic [DATA_W-1:0]     res_q;
    logic                  zero_q;
    logic                  ovf_q;
    logic                  sticky_q, sticky_d;

    logic                  accept;
    logic                  is_loadi;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     cap_res;
    logic                  cap_zero;
    logic                  cap_ovf;

    alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rf (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .we_i       (state_q == ST_WB),
        .waddr_i    (rd_q),
        .wdata_i    (res_q),
        .raddr_a_i  (ir_q.rs),
        .rdata_a_o  (rs_data),
        .raddr_b_i  (ir_q.rt),
        .rdata_b_o  (rt_data),
        .dbg_addr_i (DbgAddr),
        .dbg_data_o (DbgData)
    );

    always_comb begin
        state_d = state_q;
        InReady = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                InReady = !Reset;
                accept  = InValid && !Reset;
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign is_loadi = (ir_q.op == OP_LOADI);
    assign imm      = DATA_W'({ir_q.rs, ir_q.rt});

    // LOADI parks the ALU on AND 0,0 and substitutes the immediate.
    always_comb begin
        AluA  = '0;
        AluB  = '0;
        AluOp = OP_AND;
        if (state_q == ST_EXEC && !Reset && !is_loadi) begin
            AluA  = rs_data;
            AluB  = rt_data;
            AluOp = ir_q.op;
        end
    end

    assign cap_res  = is_loadi ? imm : AluResult;
    assign cap_zero = is_loadi ? (imm == '0) : AluZero;
    assign cap_ovf  = is_loadi ? 1'b0 : AluOverflow;

    always_comb begin
        sticky_d = sticky_q;
        if (ClearSticky) begin
            sticky_d = 1'b0;
        end
        if (state_q == ST_WB && ovf_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            if (accept) begin
                ir_q <= '{op: InOp, rd: InRd, rs: InRs, rt: InRt};
            end
            if (state_q == ST_EXEC) begin
                rd_q   <= ir_q.rd;
                res_q  <= cap_res;
                zero_q <= cap_zero;
                ovf_q  <= cap_ovf;
            end
        end
    end

    assign DoneValid      = (state_q == ST_WB) && !Reset;
    assign DoneRd         = rd_q;
    assign DoneResult     = res_q;
    assign DoneZero       = zero_q;
    assign DoneOverflow   = ovf_q;
    assign OverflowSticky = sticky_q;

endmodule

// File: tb/tb_alu_4bit_issue_ctrl.sv
// Bench for alu_4bit_issue_ctrl with a real alu_4bit behind it.
// A cycle-level reference model is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_alu_4bit_issue_ctrl;

    import alu_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [2:0] InOp = '0;
    logic [1:0] InRd = '0;
    logic [1:0] InRs = '0;
    logic [1:0] InRt = '0;
    logic [3:0] AluA;
    logic [3:0] AluB;
    logic [2:0] AluOp;
    logic [3:0] AluResult;
    logic       AluZero;
    logic       AluOverflow;
    logic       DoneValid;
    logic [1:0] DoneRd;
    logic [3:0] DoneResult;
    logic       DoneZero;
    logic       DoneOverflow;
    logic       OverflowSticky;
    logic       ClearSticky = 1'b0;
    logic [1:0] DbgAddr = '0;
    logic [3:0] DbgData;

    always #5 Clock = ~Clock;

    alu_4bit_issue_ctrl #(.DATA_W(4), .NUM_REGS(4)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InValid        (InValid),
        .InReady        (InReady),
        .InOp           (InOp),
        .InRd           (InRd),
        .InRs           (InRs),
        .InRt           (InRt),
        .AluA           (AluA),
        .AluB           (AluB),
        .AluOp          (AluOp),
        .AluResult      (AluResult),
        .AluZero        (AluZero),
        .AluOverflow    (AluOverflow),
        .DoneValid      (DoneValid),
        .DoneRd         (DoneRd),
        .DoneResult     (DoneResult),
        .DoneZero       (DoneZero),
        .DoneOverflow   (DoneOverflow),
        .OverflowSticky (OverflowSticky),
        .ClearSticky    (ClearSticky),
        .DbgAddr        (DbgAddr),
        .DbgData        (DbgData)
    );

    alu_4bit u_alu (
        .A         (AluA),
        .B         (AluB),
        .Operation (AluOp),
        .Result    (AluResult),
        .Zero      (AluZero),
        .Overflow  (AluOverflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference ALU from signed-integer arithmetic: {ovf, zero, result}.
    function automatic logic [5:0] ref_alu(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        int sa;
        int sb;
        int s;
        logic [3:0] r;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        s = 0;
        r = '0;
        v = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = sa + sb; r = s[3:0]; v = (s > 7 || s < -8); end
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd6: begin s = sa - sb; r = s[3:0]; v = (s > 7 || s < -8); end
            3'd7: begin
                s = sa - sb;
                r = {3'b000, s[3]};
                v = (s > 7 || s < -8);
            end
            default: r = '0;
        endcase
        return {v, (r == 4'd0), r};
    endfunction

    // Model: phase 0 waiting, 1 executing, 2 writing back.
    logic [3:0] m_regs [4];
    logic       m_sticky;
    int         m_phase;
    logic       m_valid = 1'b0;
    logic [2:0] m_op;
    logic [1:0] m_rd, m_rs, m_rt;
    logic [1:0] m_last_rd;
    logic [3:0] m_last_res;
    logic       m_last_zero;
    logic       m_last_ovf;

    initial begin
        forever begin
            @(negedge Clock);
            if (m_valid) begin
                logic       exec;
                logic [5:0] r;
                exec = !Reset && m_phase == 1 && m_op != OP_LOADI;
                check("InReady", InReady, !Reset && m_phase == 0);
                check("DoneValid", DoneValid, !Reset && m_phase == 2);
                check("DoneRd", DoneRd, m_last_rd);
                check("DoneResult", DoneResult, m_last_res);
                check("DoneZero", DoneZero, m_last_zero);
                check("DoneOverflow", DoneOverflow, m_last_ovf);
                check("OverflowSticky", OverflowSticky, m_sticky);
                check("DbgData", DbgData, m_regs[DbgAddr]);
                check("AluA", AluA, exec ? m_regs[m_rs] : 4'd0);
                check("AluB", AluB, exec ? m_regs[m_rt] : 4'd0);
                check("AluOp", AluOp, exec ? m_op : 3'd0);
                r = '0;
            end
            if (Reset) begin
                for (int i = 0; i < 4; i++) m_regs[i] = '0;
                m_sticky    = 1'b0;
                m_phase     = 0;
                m_op        = '0;
                m_rd        = '0;
                m_rs        = '0;
                m_rt        = '0;
                m_last_rd   = '0;
                m_last_res  = '0;
                m_last_zero = 1'b0;
                m_last_ovf  = 1'b0;
                m_valid     = 1'b1;
            end else if (m_valid) begin
                if (m_phase == 2 && m_last_ovf) m_sticky = 1'b1;
                else if (ClearSticky) m_sticky = 1'b0;
                case (m_phase)
                    0: if (InValid) begin
                        m_op = InOp;
                        m_rd = InRd;
                        m_rs = InRs;
                        m_rt = InRt;
                        m_phase = 1;
                    end
                    1: begin
                        logic [5:0] t;
                        if (m_op == OP_LOADI)
                            t = {1'b0, ({m_rs, m_rt} == 4'd0), m_rs, m_rt};
                        else
                            t = ref_alu(m_op, m_regs[m_rs], m_regs[m_rt]);
                        m_last_rd   = m_rd;
                        m_last_res  = t[3:0];
                        m_last_zero = t[4];
                        m_last_ovf  = t[5];
                        m_phase = 2;
                    end
                    default: begin
                        m_regs[m_last_rd] = m_last_res;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [1:0] rt,
                         output logic [3:0] res, output logic z,
                         output logic v, output int lat);
        logic acc;
        logic got;
        res = '0;
        z = 1'b0;
        v = 1'b0;
        lat = 0;
        @(posedge Clock);
        #1;
        InValid = 1'b1;
        InOp = op;
        InRd = rd;
        InRs = rs;
        InRt = rt;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge Clock);
            if (InReady) acc = 1'b1;
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 8'd0, 8'd1);
            return;
        end
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge Clock);
            if (DoneValid) begin
                got = 1'b1;
                lat = i;
                res = DoneResult;
                z = DoneZero;
                v = DoneOverflow;
            end
        end
        if (!got) check("done_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] res;
        logic       z;
        logic       v;
        int         lat;
        logic [8:0] rp;
        logic [8:0] dp;
        int         dcnt;
        logic       acc;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_InReady", InReady, 1'b0);
        check("rst_DoneValid", DoneValid, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("post_rst_InReady", InReady, 1'b1);
        check("post_rst_sticky", OverflowSticky, 1'b0);
        check("post_rst_dbg", DbgData, 4'd0);

        issue(OP_LOADI, 2'd1, 2'b01, 2'b11, res, z, v, lat);
        check("loadi7_res", res, 4'd7);
        issue(OP_LOADI, 2'd2, 2'b00, 2'b01, res, z, v, lat);
        check("loadi1_res", res, 4'd1);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, res, z, v, lat);
        check("add_res", res, 4'b1000);
        check("add_ovf", v, 1'b1);
        check("add_zero", z, 1'b0);
        check("add_latency", lat[7:0], 8'd2);
        @(posedge Clock);
        #1;
        DbgAddr = 2'd3;
        @(negedge Clock);
        check("add_sticky", OverflowSticky, 1'b1);
        check("add_dbg_r3", DbgData, 4'b1000);

        @(posedge Clock);
        #1;
        ClearSticky = 1'b1;
        @(posedge Clock);
        #1;
        ClearSticky = 1'b0;
        check("clear_sticky", OverflowSticky, 1'b0);
        ClearSticky = 1'b1;
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, res, z, v, lat);
        @(posedge Clock);
        #1;
        ClearSticky = 1'b0;
        check("set_wins_sticky", OverflowSticky, 1'b1);

        @(posedge Clock);
        #1;
        InValid = 1'b1;
        InOp = OP_LOADI;
        InRd = 2'd0;
        InRs = 2'b10;
        InRt = 2'b01;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            rp[i] = InReady;
            dp[i] = DoneValid;
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        check("ready_pattern", {7'd0, rp[8]}, 8'd0);
        check("ready_pattern_lo", rp[7:0], 8'b0100_1001);
        check("done_pattern_lo", dp[7:0], 8'b0010_0100);
        check("done_pattern_hi", {7'd0, dp[8]}, 8'd1);

        issue(OP_LOADI, 2'd0, 2'b01, 2'b01, res, z, v, lat);
        issue(OP_SUB, 2'd0, 2'd0, 2'd0, res, z, v, lat);
        check("sub_res", res, 4'd0);
        check("sub_zero", z, 1'b1);
        check("sub_ovf", v, 1'b0);
        issue(OP_NOR, 2'd1, 2'd0, 2'd0, res, z, v, lat);
        check("nor_res", res, 4'b1111);
        check("nor_zero", z, 1'b0);

        issue(OP_LOADI, 2'd1, 2'b11, 2'b01, res, z, v, lat);
        issue(OP_LOADI, 2'd2, 2'b01, 2'b10, res, z, v, lat);
        issue(OP_SLT, 2'd3, 2'd1, 2'd2, res, z, v, lat);
        check("slt_res", res, 4'd0);
        check("slt_zero", z, 1'b1);
        check("slt_ovf", v, 1'b1);

        @(posedge Clock);
        #1;
        InValid = 1'b1;
        InOp = OP_ADD;
        InRd = 2'd3;
        InRs = 2'd1;
        InRt = 2'd2;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge Clock);
            if (InReady) acc = 1'b1;
        end
        if (!acc) check("rst_exec_accept", 8'd0, 8'd1);
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (i == 0) check("rst_exec_ready", InReady, 1'b1);
            if (DoneValid) dcnt++;
        end
        check("rst_exec_no_done", dcnt[7:0], 8'd0);
        for (int a = 0; a < 4; a++) begin
            @(posedge Clock);
            #1;
            DbgAddr = 2'(a);
            @(negedge Clock);
            check("rst_exec_rf_zero", DbgData, 4'd0);
        end

        for (int c = 0; c < 600; c++) begin
            @(negedge Clock);
            acc = InValid && InReady;
            @(posedge Clock);
            #1;
            Reset = ($urandom % 97) == 0;
            ClearSticky = ($urandom % 8) == 0;
            DbgAddr = 2'($urandom);
            if (!InValid || acc) begin
                InValid = ($urandom % 4) != 0;
                InOp = 3'($urandom);
                InRd = 2'($urandom);
                InRs = 2'($urandom);
                InRt = 2'($urandom);
            end
        end

        Reset = 1'b0;
        InValid = 1'b0;
        ClearSticky = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
